// File: rtl/pipelined_rca_adder_if.sv
// Operand/result stream bundle for pipelined_rca_adder.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready
// are both high; the source holds its payload stable while valid is high and
// ready is low; ready may be computed without looking at valid.
interface pipelined_rca_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry add/subtract. Stage k resolves bits
// [k*SEG +: SEG]; the carry, the still-unprocessed upper operand bits and the
// finished lower sum bits travel together down the pipe. The last stage's
// registers are the output registers.
module pipelined_rca_adder #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   pipelined_rca_adder_if.slave bus
);
   localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
   localparam int STAGES   = WIDTH / SEG_SAFE;

   if (WIDTH < 2 || SEG < 1 || (WIDTH % SEG_SAFE) != 0) begin : g_param_check
      $fatal(1, "pipelined_rca_adder: WIDTH must be >= 2 and a multiple of SEG");
   end

   logic adv;
   logic last_valid;

   // Whole pipe moves together; it only freezes when a result is stuck at the output.
   assign adv          = !last_valid || bus.out_ready;
   assign bus.in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IW = WIDTH - k * SEG;  // operand bits still unprocessed on entry
      localparam int DW = (k + 1) * SEG;    // sum bits complete on exit

      logic           v_in;
      logic           c_in;
      logic [IW-1:0]  a_in;
      logic [IW-1:0]  b_in;
      logic [SEG-1:0] seg_sum;
      logic [SEG:0]   chain;
      logic [DW-1:0]  s_next;
      logic           v_q;
      logic           c_q;
      logic [DW-1:0]  s_q;

      if (k == 0) begin : g_src
         // Subtraction becomes a + ~b + !cin at the pipe entry.
         always_comb begin
            v_in   = bus.in_valid;
            a_in   = bus.a;
            b_in   = bus.b ^ {WIDTH{bus.sub}};
            c_in   = bus.cin ^ bus.sub;
            s_next = seg_sum;
         end
      end else begin : g_src
         // Pick up the skewed operands, carry and finished sum bits from the previous stage.
         always_comb begin
            v_in   = g_stage[k-1].v_q;
            a_in   = g_stage[k-1].g_ops.a_q;
            b_in   = g_stage[k-1].g_ops.b_q;
            c_in   = g_stage[k-1].c_q;
            s_next = {seg_sum, g_stage[k-1].s_q};
         end
      end

      // Ripple chain of full adders over the low SEG unprocessed bits.
      always_comb begin
         chain    = '0;
         seg_sum  = '0;
         chain[0] = c_in;
         for (int i = 0; i < SEG; i++) begin
            seg_sum[i]  = a_in[i] ^ b_in[i] ^ chain[i];
            chain[i+1]  = (a_in[i] & b_in[i]) | (chain[i] & (a_in[i] ^ b_in[i]));
         end
      end

      // Stage valid follows the pipe; payload only loads for real operations.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_in;
            if (v_in) begin
               c_q <= chain[SEG];
               s_q <= s_next;
            end
         end
      end

      if (k < STAGES - 1) begin : g_ops
         logic [IW-SEG-1:0] a_q;
         logic [IW-SEG-1:0] b_q;

         // Carry the untouched upper operand bits forward for later stages.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && v_in) begin
               a_q <= a_in[IW-1:SEG];
               b_q <= b_in[IW-1:SEG];
            end
         end
      end else begin : g_ovf
         logic ovf_q;

         // Signed overflow: carry into the MSB differs from carry out of it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (adv && v_in) begin
               ovf_q <= chain[SEG] ^ chain[SEG-1];
            end
         end
      end
   end

   assign last_valid    = g_stage[STAGES-1].v_q;
   assign bus.out_valid = last_valid;
   assign bus.sum       = g_stage[STAGES-1].s_q;
   assign bus.cout      = g_stage[STAGES-1].c_q;
   assign bus.ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Bench for pipelined_rca_adder (WIDTH=16, SEG=4): directed cases, a stalled
// stream, random traffic with backpressure and a mid-flight reset.
module tb_pipelined_rca_adder;
   localparam int W      = 16;
   localparam int SEG    = 4;
   localparam int STAGES = W / SEG;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipelined_rca_adder_if #(.WIDTH(W)) bus ();

   pipelined_rca_adder #(.WIDTH(W), .SEG(SEG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- bookkeeping ----------------
   int           n_checks  = 0;
   int           n_errors  = 0;
   int           cyc       = 0;
   int           n_out     = 0;
   logic [W+1:0] exp_q[$];
   int           acc_q[$];
   logic         chk_lat   = 1'b0;
   logic         rnd_ready = 1'b0;
   logic         hold_prev = 1'b0;
   logic [W+2:0] prev_out  = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operation's meaning.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
      longint ua, ub, sa, sb, ci, r, sr, lim;
      logic co, ov;
      logic [W-1:0] sm;
      ua  = longint'(x);
      ub  = longint'(y);
      sa  = longint'($signed(x));
      sb  = longint'($signed(y));
      ci  = c ? 64'sd1 : 64'sd0;
      lim = longint'(1) << (W - 1);
      if (!s) begin
         r  = ua + ub + ci;
         sr = sa + sb + ci;
         co = (r >= (longint'(1) << W));
      end else begin
         r  = ua - ub - ci;
         sr = sa - sb - ci;
         co = (ua >= ub + ci);
      end
      sm = r[W-1:0];
      ov = (sr >= lim) || (sr < -lim);
      return {co, ov, sm};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [W+1:0] e;
   int           ac;
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         check_eq("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (hold_prev)
            check_eq("hold_stable", {bus.out_valid, bus.cout, bus.ovf, bus.sum}, prev_out);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_out", exp_q.size(), 1);
            end else begin
               e  = exp_q.pop_front();
               ac = acc_q.pop_front();
               check_eq("result", {bus.cout, bus.ovf, bus.sum}, e);
               if (chk_lat) check_eq("latency", cyc - ac, STAGES);
               n_out++;
            end
         end
         hold_prev = bus.out_valid && !bus.out_ready;
         prev_out  = {bus.out_valid, bus.cout, bus.ovf, bus.sum};
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            acc_q.push_back(cyc);
         end
      end else begin
         hold_prev = 1'b0;
      end
   end

   always @(negedge clk) if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = x;
      bus.b        = y;
      bus.cin      = c;
      bus.sub      = s;
      #2;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (n >= 200) check_eq("send_timeout", n, 0);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_done", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] da[4] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000};
   logic [W-1:0] db[4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0000};
   logic         dc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic         ds[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int base, stall_lo, seen, guard;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      #3;
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_in_ready", bus.in_ready, 1);
      check_eq("rst_sum", bus.sum, 0);
      check_eq("rst_cout", bus.cout, 0);
      check_eq("rst_ovf", bus.ovf, 0);

      // Directed single operations, pipe otherwise empty.
      chk_lat = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(da[i], db[i], dc[i], ds[i]);
         idle();
         drain();
      end

      // Stream of 6 with a 3-cycle output stall at the first result.
      chk_lat  = 1'b0;
      base     = n_out;
      stall_lo = 0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            idle();
         end
         begin
            guard = 0;
            do begin
               @(negedge clk);
               guard++;
            end while (!bus.out_valid && guard < 50);
            check_eq("stall_first_valid", bus.out_valid, 1);
            bus.out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               #2;
               if (!bus.in_ready) stall_lo++;
               @(negedge clk);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check_eq("stall_in_ready_low", stall_lo, 3);
      check_eq("stream_count", n_out - base, 6);

      // Random traffic with bubbles and random backpressure.
      base      = n_out;
      #2 rnd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      idle();
      #2 rnd_ready = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      drain();
      check_eq("random_count", n_out - base, 40);

      // Reset with operations in flight.
      for (int i = 0; i < 3; i++)
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      idle();
      @(negedge clk);
      check_eq("pre_reset_valid", bus.out_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      check_eq("async_rst_valid", bus.out_valid, 0);
      check_eq("async_rst_sum", bus.sum, 0);
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      #3 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      check_eq("no_stale_after_reset", seen, 0);
      chk_lat = 1'b1;
      base    = n_out;
      send(16'h1234, 16'h4321, 1'b1, 1'b0);
      idle();
      drain();
      check_eq("post_reset_count", n_out - base, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES = WIDTH/SEG ripple segments, one segment per clock, with the carry registered between stages.
- Uses valid/ready handshakes on input and output, so it drops into streaming datapaths (accumulators, address generators) and sustains one operation per clock.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be ≥ 2.
- SEG, 4: bits resolved per pipeline stage. WIDTH % SEG must be 0; violation is a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result (mod 2^WIDTH)
- cout  output  1  raw carry-out of MSB; for sub, 1 means no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n low, async): all stage valid bits, out_valid, sum, cout and ovf clear to 0. All internal registers clear. In-flight operations are discarded; nothing is emitted after release.
- Input acceptance: an operation is accepted when in_valid && in_ready at the rising edge.
- Arithmetic: effective B = b ^ {WIDTH{sub}}; effective carry-in = cin ^ sub.
  - Result = a + effB + effCin, computed segment k (bits k*SEG .. k*SEG+SEG-1) in stage k.
  - Each segment is a ripple chain of full adders fed by the previous stage's registered carry.
- Skew/deskew:
  - Unprocessed upper operand segments travel alongside each operation.
  - Completed lower sum segments travel forward with it.
  - The final stage presents the full WIDTH result aligned.
- ovf = carry into MSB XOR carry out of MSB, for both add and sub. ovf is valid only with out_valid.
- Latency: STAGES cycles from acceptance to out_valid, with no stalls. Throughput is 1 op/cycle.
- Flow control:
  - Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational, no dependency on in_valid).
  - When adv = 0, every stage holds its contents and the output registers hold stable. sum/cout/ovf must not change while out_valid && !out_ready.
  - Bubbles (in_valid = 0 when adv = 1) propagate as invalid stages; order is strictly preserved.
- Simultaneous events: accept and emit in the same cycle is legal and keeps the pipe full.
- STAGES = 1 (SEG = WIDTH): degenerates to a single registered adder with latency 1.
- Output registers update only when adv = 1. When a bubble arrives, out_valid goes low; sum/cout/ovf may hold their last value.

Test Plan (WIDTH=16, SEG=4, latency 4):
- Add, no stall: a=0x7FFF, b=0x0001, cin=0, sub=0 → 4 cycles later out_valid=1, sum=0x8000, cout=0, ovf=1.
- Wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. Full-chain carry through all four stages.
- Subtract, borrow: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0.
- Subtract, overflow with borrow-in: a=0x8000, b=0x0000, cin=1, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Back-to-back with stall:
  - Stimulus: stream 6 random ops with in_valid held high; hold out_ready=0 for 3 cycles starting when the first result appears.
  - Required: in_ready low during the stall, output held stable, all 6 results emitted in order and matching the reference model, with no duplicates and no drops.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for one cycle → out_valid=0 immediately (async). After release, no stale results appear and the next op completes with latency 4.
